// File: rtl/alu_pkg.sv
// Shared definitions for the sequenced ALU: default widths, opcodes, FSM
// state encodings and flag bit positions.
package alu_pkg;

  localparam int unsigned ALU_W   = 16;
  localparam int unsigned ALU_SHW = 4;
  localparam int unsigned OPW     = 3;
  localparam int unsigned FLW     = 4;

  // Flag vector layout {Z,N,C,V}
  localparam int unsigned FLG_Z = 3;
  localparam int unsigned FLG_N = 2;
  localparam int unsigned FLG_C = 1;
  localparam int unsigned FLG_V = 0;

  typedef enum logic [OPW-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_RSV = 3'd7
  } op_e;

  // FSM encodings kept as plain constants for compatibility with older tooling
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_EXEC  = 2'd1;
  localparam state_t ST_SHIFT = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/alu_flag_unit.sv
// Combinational status-flag generator shared by single-cycle and shift ops.
// Ports:
//   result  - W-bit result of the completing op
//   carry   - carry/borrow/last-shifted-out bit
//   ovf     - signed overflow
//   clr     - force all flags to zero (reserved opcode)
//   flags_c - {Z,N,C,V}
module alu_flag_unit
  import alu_pkg::*;
#(
  parameter int unsigned W = ALU_W
) (
  input  logic [W-1:0]   result,
  input  logic           carry,
  input  logic           ovf,
  input  logic           clr,
  output logic [FLW-1:0] flags_c
);

  always_comb begin
    flags_c = '0;
    if (!clr) begin
      flags_c[FLG_Z] = (result == '0);
      flags_c[FLG_N] = result[W-1];
      flags_c[FLG_C] = carry;
      flags_c[FLG_V] = ovf;
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for the 16-bit ALU: accepts one op over a valid/ready
// request channel, executes it in one cycle (or iteratively for shifts),
// and returns a registered result and flags over a valid/ready response.
// Ports:
//   clk, rst_n              - clock, async active-low reset
//   req_valid/req_ready     - request handshake
//   req_op, req_a, req_b    - opcode and operands (B[SHW-1:0] = shift amount)
//   rsp_valid/rsp_ready     - response handshake
//   rsp_result, rsp_err     - registered result, reserved-opcode indication
//   flags                   - {Z,N,C,V} of last completed op
//   busy                    - controller not idle
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned W   = ALU_W,
  parameter int unsigned SHW = ALU_SHW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [OPW-1:0] req_op,
  input  logic [W-1:0]   req_a,
  input  logic [W-1:0]   req_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [W-1:0]   rsp_result,
  output logic           rsp_err,
  output logic [FLW-1:0] flags,
  output logic           busy
);

  state_t         state_q, state_d;
  op_e            op_q;
  logic [W-1:0]   a_q, b_q, acc_q;
  logic [SHW-1:0] cnt_q;
  logic           sh_c_q;

  logic [W:0]     sum_w, dif_w;
  logic [W-1:0]   ex_res, fin_res;
  logic           ex_c, ex_v, ex_clr;
  logic           fin_c, fin_v, fin_clr, fin_err;
  logic [FLW-1:0] fin_flags_c;
  logic           accept_c, load_done_c;

  assign accept_c    = (state_q == ST_IDLE) && req_valid;
  assign load_done_c = (state_q != ST_DONE) && (state_d == ST_DONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_op == OP_SHL || req_op == OP_SHR) state_d = ST_SHIFT;
          else                                      state_d = ST_EXEC;
        end
      end
      ST_EXEC:  state_d = ST_DONE;
      ST_SHIFT: if (cnt_q == '0) state_d = ST_DONE;
      ST_DONE:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Operand capture and iterative shifter; shifts one bit per SHIFT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_ADD;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      sh_c_q <= 1'b0;
    end else if (accept_c) begin
      op_q   <= op_e'(req_op);
      a_q    <= req_a;
      b_q    <= req_b;
      acc_q  <= req_a;
      cnt_q  <= req_b[SHW-1:0];
      sh_c_q <= 1'b0;
    end else if (state_q == ST_SHIFT && cnt_q != '0) begin
      cnt_q <= cnt_q - SHW'(1);
      if (op_q == OP_SHL) begin
        acc_q  <= {acc_q[W-2:0], 1'b0};
        sh_c_q <= acc_q[W-1];
      end else begin
        acc_q  <= {1'b0, acc_q[W-1:1]};
        sh_c_q <= acc_q[0];
      end
    end
  end

  // Single-cycle ALU; carry and borrow come from the W+1-bit sum/difference
  always_comb begin
    sum_w  = {1'b0, a_q} + {1'b0, b_q};
    dif_w  = {1'b0, a_q} - {1'b0, b_q};
    ex_res = '0;
    ex_c   = 1'b0;
    ex_v   = 1'b0;
    ex_clr = 1'b0;
    case (op_q)
      OP_ADD: begin
        ex_res = sum_w[W-1:0];
        ex_c   = sum_w[W];
        ex_v   = (a_q[W-1] == b_q[W-1]) && (sum_w[W-1] != a_q[W-1]);
      end
      OP_SUB: begin
        ex_res = dif_w[W-1:0];
        ex_c   = dif_w[W];
        ex_v   = (a_q[W-1] != b_q[W-1]) && (dif_w[W-1] != a_q[W-1]);
      end
      OP_AND:  ex_res = a_q & b_q;
      OP_OR:   ex_res = a_q | b_q;
      OP_XOR:  ex_res = a_q ^ b_q;
      OP_RSV:  ex_clr = 1'b1;
      default: ex_res = '0;
    endcase
  end

  // Completion source: shift accumulator or single-cycle ALU
  always_comb begin
    fin_res = ex_res;
    fin_c   = ex_c;
    fin_v   = ex_v;
    fin_clr = ex_clr;
    fin_err = (state_q == ST_EXEC) && (op_q == OP_RSV);
    if (state_q == ST_SHIFT) begin
      fin_res = acc_q;
      fin_c   = sh_c_q;
      fin_v   = 1'b0;
      fin_clr = 1'b0;
    end
  end

  alu_flag_unit #(.W(W)) u_flags (
    .result  (fin_res),
    .carry   (fin_c),
    .ovf     (fin_v),
    .clr     (fin_clr),
    .flags_c (fin_flags_c)
  );

  // Registered outputs; result/flags load only on entry to DONE and persist
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      flags      <= '0;
    end else begin
      req_ready <= (state_d == ST_IDLE);
      busy      <= (state_d != ST_IDLE);
      rsp_valid <= (state_d == ST_DONE);
      if (load_done_c) begin
        rsp_result <= fin_res;
        rsp_err    <= fin_err;
        flags      <= fin_flags_c;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed cases plus random ops
// compared against an arithmetic reference model.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [15:0] req_a = 16'd0;
  logic [15:0] req_b = 16'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic        rsp_err;
  logic [3:0]  flags;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] last_res;
  logic [3:0]  last_flags;
  logic        last_err;

  alu_seq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .flags      (flags),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation's definition
  function automatic void model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic [3:0] f,
                                output logic e, output int lat);
    int ia, ib, sa, sb, s, n;
    logic c, v;
    ia = int'(a);
    ib = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    c = 1'b0; v = 1'b0; e = 1'b0; lat = 2; r = 16'h0;
    case (op)
      3'd0: begin
        s = ia + ib; r = 16'(s); c = (s > 65535);
        v = ((sa + sb) > 32767) || ((sa + sb) < -32768);
      end
      3'd1: begin
        s = ia - ib; r = 16'(s); c = (ia < ib);
        v = ((sa - sb) > 32767) || ((sa - sb) < -32768);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin
        n = ib % 16; r = 16'(ia << n); lat = n + 2;
        c = (n != 0) && (((ia >> (16 - n)) & 1) == 1);
      end
      3'd6: begin
        n = ib % 16; r = 16'(ia >> n); lat = n + 2;
        c = (n != 0) && (((ia >> (n - 1)) & 1) == 1);
      end
      default: begin e = 1'b1; r = 16'h0; end
    endcase
    f = e ? 4'b0000 : {(r == 16'h0), r[15], c, v};
  endfunction

  // Issue one op, check latency/response/backpressure/handshake; junk requests
  // are presented while busy and must be ignored.
  task automatic do_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input int hold);
    logic [15:0] er;
    logic [3:0]  ef;
    logic        ee;
    int          elat, lat;
    logic [31:0] snap;
    model(op, a, b, er, ef, ee, elat);
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk);
    #1;
    req_op = 3'($urandom); req_a = 16'($urandom); req_b = 16'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("req_ready_busy", 32'(req_ready), 32'd0);
      end
    end while (!rsp_valid && lat < 40);
    chk("latency", 32'(lat), 32'(elat));
    chk("result", 32'(rsp_result), 32'(er));
    chk("err", 32'(rsp_err), 32'(ee));
    chk("flags", 32'(flags), 32'(ef));
    last_res = rsp_result; last_flags = flags; last_err = rsp_err;
    snap = {8'd0, rsp_valid, req_ready, busy, rsp_err, flags, rsp_result};
    repeat (hold) begin
      @(negedge clk);
      chk("hold_stable", {8'd0, rsp_valid, req_ready, busy, rsp_err, flags, rsp_result}, snap);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_hs_ready", {29'd0, req_ready, rsp_valid, busy}, {29'd0, 3'b100});
    chk("flags_persist", 32'(flags), 32'(ef));
  endtask

  initial begin
    bit seen;
    logic [15:0] ra;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_outputs", {12'd0, req_ready, rsp_valid, busy, rsp_err, flags, rsp_result},
                       {12'd0, 4'b1000, 4'b0000, 16'h0000});
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed cases
    do_op(3'd0, 16'h7FFF, 16'h0001, 0);
    chk("add_ovf_res", 32'(last_res), 32'h8000);
    chk("add_ovf_flg", 32'(last_flags), 32'b0101);
    do_op(3'd1, 16'h1234, 16'h1234, 0);
    chk("sub_eq_flg", {12'd0, last_flags, last_res}, {12'd0, 4'b1000, 16'h0000});
    do_op(3'd1, 16'h0001, 16'h0002, 1);
    chk("sub_borrow", {12'd0, last_flags, last_res}, {12'd0, 4'b0110, 16'hFFFF});
    do_op(3'd5, 16'h8001, 16'h0003, 0);
    chk("shl3", {12'd0, last_flags, last_res}, {12'd0, 4'b0000, 16'h0008});
    do_op(3'd5, 16'h8001, 16'h0001, 0);
    chk("shl1", {12'd0, last_flags, last_res}, {12'd0, 4'b0010, 16'h0002});
    do_op(3'd6, 16'h8001, 16'h0000, 0);
    chk("shr0", {12'd0, last_flags, last_res}, {12'd0, 4'b0100, 16'h8001});
    do_op(3'd4, 16'hFFFF, 16'hFFFF, 5);
    chk("xor_bp", {12'd0, last_flags, last_res}, {12'd0, 4'b1000, 16'h0000});
    do_op(3'd7, 16'h5555, 16'h1234, 0);
    chk("rsv", {11'd0, last_err, last_flags, last_res}, {11'd0, 1'b1, 4'b0000, 16'h0000});
    do_op(3'd2, 16'h00F0, 16'h0F00, 0);
    chk("and_after_rsv", {11'd0, last_err, last_flags, last_res}, {11'd0, 1'b0, 4'b1000, 16'h0000});

    // Random ops with random backpressure
    for (int i = 0; i < 60; i++) begin
      do_op(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
    end

    // Reset during SHIFT of an SHR by 10 aborts the op
    ra = 16'($urandom);
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd6; req_a = ra; req_b = 16'd10;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_in_shift", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs", {12'd0, req_ready, rsp_valid, busy, rsp_err, flags, rsp_result},
                           {12'd0, 4'b1000, 4'b0000, 16'h0000});
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (rsp_valid || busy || !req_ready) seen = 1'b1;
    end
    chk("no_rsp_after_abort", 32'(seen), 32'd0);
    do_op(3'd0, 16'h0001, 16'hFFFF, 1);
    chk("recover_add", {12'd0, last_flags, last_res}, {12'd0, 4'b1010, 16'h0000});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
